// File: rtl/switch_cfg_loader.sv
// Configuration sequencer: streams a frame of select words into a bank of switch muxes
// one at a time, then checks a trailing XOR checksum and reports pass/fail.
module switch_cfg_loader #(
    parameter int  NUM_MUXES = 16,
    parameter int  INPUTS    = 4,
    localparam int SEL_W     = $clog2(INPUTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 cfg_valid,
    input  logic [SEL_W-1:0]     cfg_data,
    output logic                 cfg_ready,
    output logic [SEL_W-1:0]     mux_sel,
    output logic [NUM_MUXES-1:0] mux_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_ok,
    output logic                 cfg_err
);

    localparam int IDX_W = (NUM_MUXES > 1) ? $clog2(NUM_MUXES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MUXES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SEL_W-1:0]       chk_q, chk_d;
    logic [SEL_W-1:0]       mux_sel_q, mux_sel_d;
    logic [NUM_MUXES-1:0]   mux_enable_q, mux_enable_d;
    logic                   done_q, done_d;
    logic                   cfg_ok_q, cfg_ok_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [NUM_MUXES-1:0]   idx_onehot;
    logic                   accept;

    for (genvar gi = 0; gi < NUM_MUXES; gi++) begin : g_onehot
        assign idx_onehot[gi] = (idx_q == IDX_W'(gi));
    end

    assign cfg_ready = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = cfg_valid & cfg_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        chk_d        = chk_q;
        mux_sel_d    = mux_sel_q;
        mux_enable_d = '0;
        done_d       = 1'b0;
        cfg_ok_d     = cfg_ok_q;
        cfg_err_d    = cfg_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    idx_d     = '0;
                    chk_d     = '0;
                    cfg_ok_d  = 1'b0;
                    cfg_err_d = 1'b0;
                end
            end
            ST_LOAD: begin
                // Abort wins over a same-cycle accept: the word is dropped unwritten.
                if (abort) begin
                    state_d   = ST_IDLE;
                    cfg_ok_d  = 1'b0;
                    cfg_err_d = 1'b1;
                end else if (accept) begin
                    mux_sel_d    = cfg_data;
                    mux_enable_d = idx_onehot;
                    chk_d        = chk_q ^ cfg_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    cfg_ok_d  = 1'b0;
                    cfg_err_d = 1'b1;
                end else if (accept) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    cfg_ok_d  = (cfg_data == chk_q);
                    cfg_err_d = (cfg_data != chk_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            chk_q        <= '0;
            mux_sel_q    <= '0;
            mux_enable_q <= '0;
            done_q       <= 1'b0;
            cfg_ok_q     <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            chk_q        <= chk_d;
            mux_sel_q    <= mux_sel_d;
            mux_enable_q <= mux_enable_d;
            done_q       <= done_d;
            cfg_ok_q     <= cfg_ok_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign mux_sel    = mux_sel_q;
    assign mux_enable = mux_enable_q;
    assign done       = done_q;
    assign cfg_ok     = cfg_ok_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_switch_cfg_loader.sv
// Bench for switch_cfg_loader with 4 muxes of 4 inputs: expected strobes and done results
// are queued as words are driven and matched by a negedge monitor.
module tb_switch_cfg_loader;

    localparam int NM = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [SW-1:0] cfg_data = '0;
    logic          cfg_ready;
    logic [SW-1:0] mux_sel;
    logic [NM-1:0] mux_enable;
    logic          busy;
    logic          done;
    logic          cfg_ok;
    logic          cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [NM+SW-1:0] strobe_q[$];
    logic [1:0]       done_q[$];
    int               m_idx;
    logic [SW-1:0]    m_chk;

    switch_cfg_loader #(.NUM_MUXES(NM), .INPUTS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .mux_sel    (mux_sel),
        .mux_enable (mux_enable),
        .busy       (busy),
        .done       (done),
        .cfg_ok     (cfg_ok),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    // Every strobe and every done pulse must match a queued expectation.
    always @(negedge clk) begin
        logic [NM+SW-1:0] es;
        logic [1:0]       ed;
        if (mux_enable !== '0) begin
            n_checks++;
            if (strobe_q.size() == 0) begin
                n_errors++;
                $display("FAIL strobe_unexpected enable=%b sel=%0d required no strobe", mux_enable, mux_sel);
            end else begin
                es = strobe_q.pop_front();
                if ({mux_enable, mux_sel} !== es) begin
                    n_errors++;
                    $display("FAIL strobe enable=%b sel=%0d required enable=%b sel=%0d",
                             mux_enable, mux_sel, es[NM+SW-1:SW], es[SW-1:0]);
                end else begin
                    $display("strobe enable=%b sel=%0d ok", mux_enable, mux_sel);
                end
            end
        end
        if (done !== 1'b0) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_errors++;
                $display("FAIL done_unexpected done=%b ok=%b err=%b required no done", done, cfg_ok, cfg_err);
            end else begin
                ed = done_q.pop_front();
                if ({cfg_ok, cfg_err} !== ed) begin
                    n_errors++;
                    $display("FAIL done_result ok=%b err=%b required ok=%b err=%b", cfg_ok, cfg_err, ed[1], ed[0]);
                end else begin
                    $display("done ok=%b err=%b ok", cfg_ok, cfg_err);
                end
            end
        end
    end

    task automatic begin_frame(input logic with_abort);
        start = 1'b1;
        abort = with_abort;
        m_idx = 0;
        m_chk = '0;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idle_gaps(input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                cfg_valid = 1'b0;
                cfg_data  = SW'($urandom);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic send_word(input logic [SW-1:0] d, input bit gaps, input logic strt);
        logic [NM-1:0] oh;
        idle_gaps(gaps);
        oh = NM'(1) << m_idx;
        strobe_q.push_back({oh, d});
        m_chk = m_chk ^ d;
        m_idx++;
        cfg_valid = 1'b1;
        cfg_data  = d;
        start     = strt;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic send_check(input logic [SW-1:0] d, input bit gaps, input logic strt);
        idle_gaps(gaps);
        done_q.push_back((d == m_chk) ? 2'b10 : 2'b01);
        cfg_valid = 1'b1;
        cfg_data  = d;
        start     = strt;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (strobe_q.size() != 0 || done_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_pending strobes=%0d dones=%0d required 0 0", name, strobe_q.size(), done_q.size());
            strobe_q.delete();
            done_q.delete();
        end
    endtask

    task automatic check_result(input string name, input logic ok, input logic err, input logic [SW-1:0] sel);
        n_checks++;
        if ({cfg_ok, cfg_err, busy, mux_sel} !== {ok, err, 1'b0, sel}) begin
            n_errors++;
            $display("FAIL %s ok=%b err=%b busy=%b sel=%0d required ok=%b err=%b busy=0 sel=%0d",
                     name, cfg_ok, cfg_err, busy, mux_sel, ok, err, sel);
        end else begin
            $display("%s ok=%b err=%b sel=%0d", name, cfg_ok, cfg_err, mux_sel);
        end
        check_drained(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cfg_ready, mux_sel, mux_enable, busy, done, cfg_ok, cfg_err} !== '0) begin
            n_errors++;
            $display("FAIL reset ready=%b sel=%0d en=%b busy=%b done=%b ok=%b err=%b required all 0",
                     cfg_ready, mux_sel, mux_enable, busy, done, cfg_ok, cfg_err);
        end else begin
            $display("reset outputs all 0");
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        begin_frame(1'b0);
        n_checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_busy ready=%b busy=%b required 1 1", cfg_ready, busy);
        end
        send_word(2'd1, 0, 0);
        send_word(2'd2, 0, 0);
        send_word(2'd3, 0, 0);
        send_word(2'd0, 0, 0);
        send_check(2'd0, 0, 0);
        check_result("basic", 1'b1, 1'b0, 2'd0);
    endtask

    task automatic test_bad_checksum();
        begin_frame(1'b0);
        send_word(2'd1, 0, 0);
        send_word(2'd2, 0, 0);
        send_word(2'd3, 0, 0);
        send_word(2'd0, 0, 0);
        send_check(2'd2, 0, 0);
        check_result("bad_checksum", 1'b0, 1'b1, 2'd0);
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            begin_frame(1'b0);
            send_word(2'd1, 1, 0);
            send_word(2'd2, 1, 0);
            send_word(2'd3, 1, 0);
            send_word(2'd0, 1, 0);
            send_check(2'd0, 1, 0);
            check_result("gaps", 1'b1, 1'b0, 2'd0);
        end
    endtask

    task automatic test_abort();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if ({busy, cfg_ok, cfg_err} !== 3'b010) begin
            n_errors++;
            $display("FAIL abort_idle busy=%b ok=%b err=%b required 0 1 0", busy, cfg_ok, cfg_err);
        end
        begin_frame(1'b0);
        send_word(2'd1, 0, 0);
        send_word(2'd2, 0, 0);
        cfg_valid = 1'b1;
        cfg_data  = 2'd3;
        abort     = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk); #1;
        check_result("abort", 1'b0, 1'b1, 2'd2);
        begin_frame(1'b1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL start_beats_abort busy=%b required 1", busy);
        end
        send_word(2'd1, 0, 0);
        send_word(2'd2, 0, 0);
        send_word(2'd3, 0, 0);
        send_word(2'd0, 0, 0);
        send_check(2'd0, 0, 0);
        check_result("after_abort", 1'b1, 1'b0, 2'd0);
    endtask

    task automatic test_reset_mid_frame();
        begin_frame(1'b0);
        send_word(2'd2, 0, 0);
        send_word(2'd1, 0, 0);
        @(negedge clk);
        reset     = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 2'd3;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({cfg_ready, mux_sel, mux_enable, busy, done, cfg_ok, cfg_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid ready=%b sel=%0d en=%b busy=%b done=%b ok=%b err=%b required all 0",
                     cfg_ready, mux_sel, mux_enable, busy, done, cfg_ok, cfg_err);
        end
        repeat (3) @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        n_checks++;
        if ({cfg_ready, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_mid_idle ready=%b busy=%b required 0 0", cfg_ready, busy);
        end
        check_result("reset_mid", 1'b0, 1'b0, 2'd0);
    endtask

    task automatic test_start_while_busy();
        begin_frame(1'b0);
        send_word(2'd1, 0, 0);
        send_word(2'd2, 0, 1);
        send_word(2'd3, 0, 0);
        send_word(2'd0, 0, 1);
        send_check(2'd0, 0, 1);
        check_result("start_busy", 1'b1, 1'b0, 2'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_gaps();
        test_abort();
        test_reset_mid_frame();
        test_start_while_busy();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
